// File: rtl/modm_updown_counter.sv
// -----------------------------------------------------------------------------
// modm_updown_counter
//
// Modulo-MODULUS up/down counter with programmable step, wrap or saturate
// boundary handling, synchronous load and sticky status flags.
//
// Parameters
//   WIDTH    count register width in bits (2..16)
//   MODULUS  count range is 0..MODULUS-1 (2..2^WIDTH)
//
// Ports
//   Clk       in   rising-edge clock
//   reset_n   in   synchronous active-low reset
//   En        in   count enable
//   UpOrDown  in   1 counts up, 0 counts down
//   Sat       in   1 saturates at the bound, 0 wraps modulo MODULUS
//   Step      in   amount added/subtracted per enabled cycle
//   Load      in   synchronous load strobe (has priority over En)
//   LoadVal   in   value to load; out-of-range values clamp to MODULUS-1
//   ClrFlags  in   clears Ovf and Err (a same-cycle set wins)
//   Count     out  registered count
//   Carry     out  registered pulse on an up-direction boundary event
//   Borrow    out  registered pulse on a down-direction boundary event
//   AtMax     out  Count == MODULUS-1
//   AtMin     out  Count == 0
//   Ovf       out  sticky: any wrap or clamp happened
//   Err       out  sticky: an out-of-range load happened
// -----------------------------------------------------------------------------
module modm_updown_counter #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 200
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             En,
  input  logic             UpOrDown,
  input  logic             Sat,
  input  logic [WIDTH-1:0] Step,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             ClrFlags,
  output logic [WIDTH-1:0] Count,
  output logic             Carry,
  output logic             Borrow,
  output logic             AtMax,
  output logic             AtMin,
  output logic             Ovf,
  output logic             Err
);

  // Arithmetic is carried at WIDTH+1 bits: MODULUS itself may equal 2^WIDTH
  // and Count+Step may reach nearly twice that.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [WIDTH:0] count_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] step_c;     // Step clamped to MODULUS-1
  logic [WIDTH:0] load_x;
  logic [WIDTH:0] sum_x;      // Count + Step
  logic [WIDTH:0] up_wrap_x;  // Count + Step - MODULUS
  logic [WIDTH:0] diff_x;     // Count - Step (valid when Count >= Step)
  logic [WIDTH:0] dn_wrap_x;  // Count + MODULUS - Step (valid when Count < Step)

  assign count_x   = {1'b0, count_q};
  assign step_x    = {1'b0, Step};
  assign load_x    = {1'b0, LoadVal};
  assign step_c    = (step_x >= MOD_X) ? MAX_X : step_x;
  assign sum_x     = count_x + step_c;
  assign up_wrap_x = sum_x - MOD_X;
  assign diff_x    = count_x - step_c;
  assign dn_wrap_x = count_x + MOD_X - step_c;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    ovf_d    = ClrFlags ? 1'b0 : ovf_q;
    err_d    = ClrFlags ? 1'b0 : err_q;

    if (Load) begin
      if (load_x > MAX_X) begin
        count_d = MAX_C;
        err_d   = 1'b1;
      end else begin
        count_d = LoadVal;
      end
    end else if (En) begin
      if (UpOrDown) begin
        if (sum_x > MAX_X) begin
          // Boundary event: pulses even when saturated and already at MAX.
          carry_d = 1'b1;
          ovf_d   = 1'b1;
          count_d = Sat ? MAX_C : up_wrap_x[WIDTH-1:0];
        end else begin
          count_d = sum_x[WIDTH-1:0];
        end
      end else begin
        if (count_x >= step_c) begin
          count_d = diff_x[WIDTH-1:0];
        end else begin
          borrow_d = 1'b1;
          ovf_d    = 1'b1;
          count_d  = Sat ? '0 : dn_wrap_x[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign Count  = count_q;
  assign Carry  = carry_q;
  assign Borrow = borrow_q;
  assign Ovf    = ovf_q;
  assign Err    = err_q;
  assign AtMax  = (count_q == MAX_C);
  assign AtMin  = (count_q == '0);

endmodule

// File: doc/modm_updown_counter.md
MODM_UPDOWN_COUNTER -- requirements
Module: modm_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the count register width in bits (legal 2..16).
REQ-002 SHALL have parameter MODULUS, default 200, giving the count range 0..MODULUS-1 (legal 2..2^WIDTH).
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have port Clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port En  input  1  count enable.
REQ-007 SHALL have port UpOrDown  input  1  direction: 1 counts up, 0 counts down.
REQ-008 SHALL have port Sat  input  1  boundary mode: 1 saturates, 0 wraps modulo MODULUS.
REQ-009 SHALL have port Step  input  WIDTH  increment or decrement amount per enabled cycle.
REQ-010 SHALL have port Load  input  1  synchronous load strobe.
REQ-011 SHALL have port LoadVal  input  WIDTH  value to load.
REQ-012 SHALL have port ClrFlags  input  1  clears the sticky flags Ovf and Err.
REQ-013 SHALL have port Count  output  WIDTH  registered count value.
REQ-014 SHALL have port Carry  output  1  registered one-cycle pulse on an up-direction boundary event.
REQ-015 SHALL have port Borrow  output  1  registered one-cycle pulse on a down-direction boundary event.
REQ-016 SHALL have port AtMax  output  1  combinational flag, Count == MODULUS-1.
REQ-017 SHALL have port AtMin  output  1  combinational flag, Count == 0.
REQ-018 SHALL have port Ovf  output  1  sticky flag, set on any wrap or clamp.
REQ-019 SHALL have port Err  output  1  sticky flag, set on an out-of-range load.

Function
REQ-020 SHALL update all registers only on the rising edge of Clk; priority is reset_n low, then Load, then En.
REQ-021 SHALL compute all next-count arithmetic at WIDTH+1 bits so that no intermediate sum overflows.
REQ-022 SHALL, when Load=1 and LoadVal <= MODULUS-1, set Count to LoadVal; Carry and Borrow are 0 that cycle.
REQ-023 SHALL, when Load=1 and LoadVal > MODULUS-1, set Count to MODULUS-1 and set Err.
REQ-024 SHALL hold Count and drive Carry=Borrow=0 when Load=0 and En=0.
REQ-025 SHALL, for En=1 and UpOrDown=1 with Count+Step <= MODULUS-1, set Count to Count+Step.
REQ-026 SHALL, for En=1 and UpOrDown=1 with Count+Step > MODULUS-1: if Sat=0, set Count to Count+Step-MODULUS; if Sat=1, set Count to MODULUS-1. Either way, pulse Carry and set Ovf.
REQ-027 SHALL, for En=1 and UpOrDown=0 with Count >= Step, set Count to Count-Step.
REQ-028 SHALL, for En=1 and UpOrDown=0 with Count < Step: if Sat=0, set Count to Count+MODULUS-Step; if Sat=1, set Count to 0. Either way, pulse Borrow and set Ovf.
REQ-029 SHALL treat Step=0 with En=1 as a hold, with no Carry, Borrow or Ovf.
REQ-030 SHALL limit legal Step to 0..MODULUS-1; behaviour for Step >= MODULUS is a clamp to MODULUS-1 applied before arithmetic.
REQ-031 SHALL pulse Carry (or Borrow) whenever the saturate clamp condition is met, including when Count is already at the bound and stays there.
REQ-032 SHALL, when ClrFlags=1, clear Ovf and Err next cycle, except that a set condition in the same cycle wins.
REQ-033 SHALL let the direction and Sat inputs change on any cycle and take effect on the next enabled edge, with no pipeline latency.

Reset
REQ-034 SHALL, with reset_n=0 at a rising edge, set Count=0, Carry=0, Borrow=0, Ovf=0, Err=0, regardless of Load, En or ClrFlags.
REQ-035 SHALL treat reset_n as having no asynchronous effect; outputs are unchanged until the next rising Clk edge.
REQ-036 SHALL let reset asserted mid-count abort the count, and resume from 0 on the first edge after reset_n=1.

Verification (WIDTH=8, MODULUS=200)
REQ-037 SHALL verify: reset, then Sat=0, up, Step=1, En=1 for 200 cycles -> Count 0..199, then 0; Carry pulses exactly once, at the 199->0 transition; Ovf=1.
REQ-038 SHALL verify: Load 195, then up, Step=10, Sat=0 -> Count=5, Carry=1; the same with Sat=1 -> Count=199, Carry=1 and held on a further step.
REQ-039 SHALL verify: Load 3, then down, Step=5, Sat=0 -> Count=198, Borrow=1; the same with Sat=1 -> Count=0, Borrow=1.
REQ-040 SHALL verify: Load with LoadVal=250 -> Count=199, Err=1; ClrFlags=1 -> Err=0 and Ovf=0 next cycle.
REQ-041 SHALL verify: Load=1 and En=1 together with LoadVal=7 -> Count=7, no Carry or Borrow.
REQ-042 SHALL verify: reset_n=0 while counting at Count=120 with En=1 -> Count=0 and all flags 0 on that edge; count resumes 1, 2, ... after release.
